execute_mul_pipe: RTL and testbench
===================================

Name: execute_mul_pipe

Overview:
Parametrised, pipelined successor to the single-cycle multiply execute unit. It pops issued multiply ops from the issue→mul FIFO and computes the RV M-extension products mul, mulh, mulhsu and mulhu through a configurable number of pipeline stages. Results go to the mul writeback port, with a bypass feedback channel to issue. New versus the single-cycle unit: writeback back-pressure, multiple ops in flight, and whole-pipeline flush.

Parameters:
XLEN, 32, operand/result width
STAGES, 3, pipeline depth (>=1); pop-to-writeback latency in cycles
ROB_ID_WIDTH, 7, ROB id width
PHY_REG_ID_WIDTH, 6, physical register id width
EXC_ID_WIDTH, 5, exception id width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
in_fifo_valid  in  1  issue_mul_fifo_data_out_valid
in_enable  in  1  pack enable
in_inst_valid  in  1  pack valid (0 = invalid instruction slot)
in_has_exception  in  1  upstream exception flag
in_exception_id  in  EXC_ID_WIDTH  exception id
in_exception_value  in  XLEN  exception value
in_rob_id  in  ROB_ID_WIDTH  ROB id
in_rd_phy  in  PHY_REG_ID_WIDTH  destination physical reg
in_rd_enable  in  1  rd written
in_need_rename  in  1  rd renamed
in_src1  in  XLEN  operand 1
in_src2  in  XLEN  operand 2
in_mul_op  in  2  0 mul, 1 mulh, 2 mulhsu, 3 mulhu
fifo_pop  out  1  pop issue FIFO this cycle
commit_flush  in  1  commit_feedback_pack.enable & flush
wb_full  in  1  writeback port cannot accept
wb_we  out  1  writeback write enable
wb_flush  out  1  writeback port flush
wb_enable, wb_inst_valid, wb_has_exception  out  1 each  forwarded flags
wb_exception_id  out  EXC_ID_WIDTH
wb_exception_value  out  XLEN
wb_rob_id  out  ROB_ID_WIDTH
wb_rd_phy  out  PHY_REG_ID_WIDTH
wb_rd_enable, wb_need_rename  out  1 each
wb_rd_value  out  XLEN  result
fb_enable  out  1  feedback valid
fb_phy_id  out  PHY_REG_ID_WIDTH
fb_value  out  XLEN

Behaviour:
- State: STAGES entries s[0..STAGES-1], each with an occupied bit plus all forwarded fields and the XLEN result.
- Reset (rst=0, async): all occupied bits cleared. fifo_pop, wb_we and fb_enable are 0. wb_flush follows commit_flush. All wb_*/fb_* data outputs are 0.
- Stall: stall = s[STAGES-1].occupied & wb_full. While stalled, every stage holds. Bubbles are not collapsed.
- Pop: fifo_pop = in_fifo_valid & in_enable & ~stall & ~commit_flush (combinational).
- Advance (posedge, ~stall):
  - s[0] <= popped op, occupied = fifo_pop.
  - s[i] <= s[i-1].
- Result:
  - Computed from in_src1/in_src2 at entry as a 2*XLEN product.
  - mul: low XLEN, signed. mulh: high XLEN, signed×signed. mulhsu: high XLEN, src1 signed × src2 unsigned. mulhu: high XLEN, unsigned.
  - Synthesis may retime the product across stages.
  - If in_has_exception or ~in_inst_valid, the result is 0.
- Outputs are driven from s[STAGES-1]:
  - wb_we = occupied & ~wb_full & ~commit_flush.
  - wb_flush = commit_flush.
  - fb_enable = wb_we & inst_valid & ~has_exception & rd_enable & need_rename.
  - fb_phy_id = rd_phy; fb_value = rd_value.
- Latency: an op popped in cycle N is presented with wb_we=1 in cycle N+STAGES, provided there are no stalls.
- Throughput: 1 op/cycle. Program order is preserved.
- Flush: commit_flush=1 forces fifo_pop=0, wb_we=0 and fb_enable=0 that cycle, and clears every occupied bit at the next edge. This holds even while stalled, and flush has priority over stall.
- Exceptions: exception fields pass through unchanged and the op is still written back (wb_we=1). Feedback is suppressed.
- When an output is not valid, its wb_*/fb_* data fields hold their last value. The verifier checks them only when wb_we=1.

Test Plan:
Setup for all scenarios: XLEN=32, STAGES=3.
1. Reset: hold rst=0, then release; in_fifo_valid=0 → fifo_pop=0, wb_we=0, fb_enable=0, wb_flush=0 for 5 cycles.
2. Basic multiply: mul 12×6, rd_phy=10, rd_enable=need_rename=1, popped at cycle N → cycle N+3: wb_we=1, wb_rd_value=72, fb_enable=1, fb_phy_id=10, fb_value=72. Cycles N+1 and N+2 show wb_we=0.
3. High-half ops: src1=src2=0xFFFFFFFF, ops mulh, mulhsu, mulhu, mul back-to-back → consecutive writebacks 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE, 0x00000001.
4. Back-pressure: 4 back-to-back ops; assert wb_full for 2 cycles when the first reaches the output → wb_we=0 and fifo_pop=0 during the stall. Then all 4 ops are written in order with no loss or duplication.
5. Flush mid-flight: 2 ops in flight, commit_flush=1 for one cycle → wb_flush=1, wb_we=0 that cycle. No writeback occurs for the flushed ops. A new op popped afterwards appears 3 cycles later.
6. Exception and async reset:
   - Exception pass-through: has_exception=1, exception_id=2 → wb_we=1, wb_has_exception=1, wb_exception_id=2, wb_rd_value=0, fb_enable=0.
   - Async reset mid-op: rst=0 between clock edges → wb_we=0 immediately, and the pipeline is empty after release.

Source files
------------

// File: rtl/execute_mul_pipe_if.sv
// Issue-FIFO, commit-flush, writeback and bypass-feedback signals of the pipelined
// multiply execute unit. The master side is the surrounding core; the slave side is the unit.
interface execute_mul_pipe_if #(
  parameter int XLEN             = 32,
  parameter int ROB_ID_WIDTH     = 7,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int EXC_ID_WIDTH     = 5
) ();
  logic                        in_fifo_valid;
  logic                        in_enable;
  logic                        in_inst_valid;
  logic                        in_has_exception;
  logic [EXC_ID_WIDTH-1:0]     in_exception_id;
  logic [XLEN-1:0]             in_exception_value;
  logic [ROB_ID_WIDTH-1:0]     in_rob_id;
  logic [PHY_REG_ID_WIDTH-1:0] in_rd_phy;
  logic                        in_rd_enable;
  logic                        in_need_rename;
  logic [XLEN-1:0]             in_src1;
  logic [XLEN-1:0]             in_src2;
  logic [1:0]                  in_mul_op;
  logic                        fifo_pop;

  logic                        commit_flush;

  logic                        wb_full;
  logic                        wb_we;
  logic                        wb_flush;
  logic                        wb_enable;
  logic                        wb_inst_valid;
  logic                        wb_has_exception;
  logic [EXC_ID_WIDTH-1:0]     wb_exception_id;
  logic [XLEN-1:0]             wb_exception_value;
  logic [ROB_ID_WIDTH-1:0]     wb_rob_id;
  logic [PHY_REG_ID_WIDTH-1:0] wb_rd_phy;
  logic                        wb_rd_enable;
  logic                        wb_need_rename;
  logic [XLEN-1:0]             wb_rd_value;

  logic                        fb_enable;
  logic [PHY_REG_ID_WIDTH-1:0] fb_phy_id;
  logic [XLEN-1:0]             fb_value;

  modport master (
    output in_fifo_valid, in_enable, in_inst_valid, in_has_exception, in_exception_id,
           in_exception_value, in_rob_id, in_rd_phy, in_rd_enable, in_need_rename,
           in_src1, in_src2, in_mul_op, commit_flush, wb_full,
    input  fifo_pop, wb_we, wb_flush, wb_enable, wb_inst_valid, wb_has_exception,
           wb_exception_id, wb_exception_value, wb_rob_id, wb_rd_phy, wb_rd_enable,
           wb_need_rename, wb_rd_value, fb_enable, fb_phy_id, fb_value
  );

  modport slave (
    input  in_fifo_valid, in_enable, in_inst_valid, in_has_exception, in_exception_id,
           in_exception_value, in_rob_id, in_rd_phy, in_rd_enable, in_need_rename,
           in_src1, in_src2, in_mul_op, commit_flush, wb_full,
    output fifo_pop, wb_we, wb_flush, wb_enable, wb_inst_valid, wb_has_exception,
           wb_exception_id, wb_exception_value, wb_rob_id, wb_rd_phy, wb_rd_enable,
           wb_need_rename, wb_rd_value, fb_enable, fb_phy_id, fb_value
  );
endinterface

// File: rtl/execute_mul_pipe.sv
// Pipelined RV M-extension multiply unit (mul/mulh/mulhsu/mulhu) with writeback
// back-pressure, several ops in flight, whole-pipeline flush and bypass feedback.
module execute_mul_pipe #(
  parameter int XLEN             = 32,
  parameter int STAGES           = 3,
  parameter int ROB_ID_WIDTH     = 7,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int EXC_ID_WIDTH     = 5
) (
  input  logic                clk,
  input  logic                rst,
  execute_mul_pipe_if.slave   bus
);

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef struct packed {
    logic                        enable;
    logic                        inst_valid;
    logic                        has_exception;
    logic [EXC_ID_WIDTH-1:0]     exception_id;
    logic [XLEN-1:0]             exception_value;
    logic [ROB_ID_WIDTH-1:0]     rob_id;
    logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
    logic                        rd_enable;
    logic                        need_rename;
    logic [XLEN-1:0]             rd_value;
  } stage_t;

  stage_t              stage_q [STAGES];
  logic [STAGES-1:0]   occ_q;
  stage_t              entry;
  stage_t              last;

  logic                stall;
  logic                fifo_pop;
  logic                a_sign;
  logic                b_sign;
  logic [2*XLEN-1:0]   a_ext;
  logic [2*XLEN-1:0]   b_ext;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     result;

  assign last     = stage_q[STAGES-1];
  assign stall    = occ_q[STAGES-1] & bus.wb_full;
  assign fifo_pop = bus.in_fifo_valid & bus.in_enable & ~stall & ~bus.commit_flush;

  // Sign-extending both operands to 2*XLEN makes one modular multiply cover
  // every signedness mix; the low half is the same for all four ops.
  always_comb begin
    a_sign = (bus.in_mul_op != OP_MULHU) & bus.in_src1[XLEN-1];
    b_sign = (bus.in_mul_op == OP_MULH)  & bus.in_src2[XLEN-1];
    a_ext  = {{XLEN{a_sign}}, bus.in_src1};
    b_ext  = {{XLEN{b_sign}}, bus.in_src2};
    prod   = a_ext * b_ext;
    result = (bus.in_mul_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (bus.in_has_exception || !bus.in_inst_valid) result = '0;
  end

  always_comb begin
    entry                 = '0;
    entry.enable          = bus.in_enable;
    entry.inst_valid      = bus.in_inst_valid;
    entry.has_exception   = bus.in_has_exception;
    entry.exception_id    = bus.in_exception_id;
    entry.exception_value = bus.in_exception_value;
    entry.rob_id          = bus.in_rob_id;
    entry.rd_phy          = bus.in_rd_phy;
    entry.rd_enable       = bus.in_rd_enable;
    entry.need_rename     = bus.in_need_rename;
    entry.rd_value        = result;
  end

  // Payloads only move behind an occupied entry, so a bubble reaching the last
  // stage leaves the previous writeback data on the output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
      // NOTE: payload registers are reset as well so every wb_*/fb_* output reads 0 out of reset.
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else if (bus.commit_flush) begin
      occ_q <= '0;
    end else if (!stall) begin
      occ_q[0] <= fifo_pop;
      if (fifo_pop) stage_q[0] <= entry;
      for (int i = 1; i < STAGES; i++) begin
        occ_q[i] <= occ_q[i-1];
        if (occ_q[i-1]) stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign bus.fifo_pop           = fifo_pop;
  assign bus.wb_we              = occ_q[STAGES-1] & ~bus.wb_full & ~bus.commit_flush;
  assign bus.wb_flush           = bus.commit_flush;
  assign bus.wb_enable          = last.enable;
  assign bus.wb_inst_valid      = last.inst_valid;
  assign bus.wb_has_exception   = last.has_exception;
  assign bus.wb_exception_id    = last.exception_id;
  assign bus.wb_exception_value = last.exception_value;
  assign bus.wb_rob_id          = last.rob_id;
  assign bus.wb_rd_phy          = last.rd_phy;
  assign bus.wb_rd_enable       = last.rd_enable;
  assign bus.wb_need_rename     = last.need_rename;
  assign bus.wb_rd_value        = last.rd_value;
  assign bus.fb_enable          = bus.wb_we & last.inst_valid & ~last.has_exception
                                & last.rd_enable & last.need_rename;
  assign bus.fb_phy_id          = last.rd_phy;
  assign bus.fb_value           = last.rd_value;

endmodule

// File: tb/tb_execute_mul_pipe.sv
// Directed bench for execute_mul_pipe (XLEN=32, STAGES=3): a vector table streamed
// back-to-back, then hand-written back-pressure, flush and async-reset sequences.
module tb_execute_mul_pipe;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_mul_pipe_if #(.XLEN(32), .ROB_ID_WIDTH(7), .PHY_REG_ID_WIDTH(6), .EXC_ID_WIDTH(5)) bus ();

  execute_mul_pipe #(
    .XLEN(32), .STAGES(LAT), .ROB_ID_WIDTH(7), .PHY_REG_ID_WIDTH(6), .EXC_ID_WIDTH(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        inst_valid;
    logic        has_exc;
    logic [4:0]  exc_id;
    logic        rd_en;
    logic        need_rename;
    logic [5:0]  rd_phy;
    logic [31:0] exp_val;
    logic        exp_fb;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
    vec_t v;
    v.op = op; v.src1 = a; v.src2 = b;
    v.inst_valid = 1'b1; v.has_exc = 1'b0; v.exc_id = 5'd0;
    v.rd_en = 1'b1; v.need_rename = 1'b1; v.rd_phy = 6'd10;
    v.exp_val = exp; v.exp_fb = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic valid, input logic [6:0] rob);
    bus.in_fifo_valid      = valid;
    bus.in_enable          = 1'b1;
    bus.in_inst_valid      = v.inst_valid;
    bus.in_has_exception   = v.has_exc;
    bus.in_exception_id    = v.exc_id;
    bus.in_exception_value = v.src1 ^ v.src2;
    bus.in_rob_id          = rob;
    bus.in_rd_phy          = v.rd_phy;
    bus.in_rd_enable       = v.rd_en;
    bus.in_need_rename     = v.need_rename;
    bus.in_src1            = v.src1;
    bus.in_src2            = v.src2;
    bus.in_mul_op          = v.op;
  endtask

  vec_t        vec [15];
  vec_t        idle;
  logic [31:0] got [$];
  logic [31:0] bp_exp [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(2'd0, 32'd0, 32'd0, 32'd0);
    drive(idle, 1'b0, 7'd0);
    bus.in_enable    = 1'b0;
    bus.commit_flush = 1'b0;
    bus.wb_full      = 1'b0;

    vec[0]  = mk(2'd0, 32'd12,        32'd6,        32'd72);
    vec[1]  = mk(2'd1, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000);
    vec[2]  = mk(2'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF);
    vec[3]  = mk(2'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE);
    vec[4]  = mk(2'd0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001);
    vec[5]  = mk(2'd1, 32'h80000000,  32'h80000000, 32'h40000000);
    vec[6]  = mk(2'd2, 32'h80000000,  32'h80000000, 32'hC0000000);
    vec[7]  = mk(2'd3, 32'h80000000,  32'd2,        32'h00000001);
    vec[8]  = mk(2'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB);
    vec[9]  = mk(2'd1, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF);
    vec[10] = mk(2'd0, 32'd5,         32'd5,        32'd0);
    vec[10].inst_valid = 1'b0; vec[10].exp_fb = 1'b0;
    vec[11] = mk(2'd0, 32'd3,         32'd3,        32'd0);
    vec[11].has_exc = 1'b1; vec[11].exc_id = 5'd2; vec[11].exp_fb = 1'b0;
    vec[12] = mk(2'd0, 32'd3,         32'd4,        32'd12);
    vec[12].rd_en = 1'b0; vec[12].exp_fb = 1'b0;
    vec[13] = mk(2'd2, 32'd2,         32'hFFFFFFFF, 32'h00000001);
    vec[14] = mk(2'd2, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF);
    for (int i = 1; i < 15; i++) if (i != 11) vec[i].rd_phy = 6'(10 + i);

    // Reset state, both while held and for 5 idle cycles after release
    repeat (2) @(negedge clk);
    #1;
    check("rst_wb_we",       64'(bus.wb_we),       64'd0);
    check("rst_fifo_pop",    64'(bus.fifo_pop),    64'd0);
    check("rst_wb_rd_value", 64'(bus.wb_rd_value), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("idle_fifo_pop",  64'(bus.fifo_pop),  64'd0);
      check("idle_wb_we",     64'(bus.wb_we),     64'd0);
      check("idle_fb_enable", 64'(bus.fb_enable), 64'd0);
      check("idle_wb_flush",  64'(bus.wb_flush),  64'd0);
    end

    // Vector table streamed back-to-back: vector c is popped in cycle c, written in c+LAT
    for (int c = 0; c < 15 + LAT; c++) begin
      @(negedge clk);
      if (c < 15) drive(vec[c], 1'b1, 7'(c)); else drive(idle, 1'b0, 7'd0);
      #1;
      if (c < 15) check("vec_fifo_pop", 64'(bus.fifo_pop), 64'd1);
      check("vec_wb_we", 64'(bus.wb_we), (c >= LAT) ? 64'd1 : 64'd0);
      if (c >= LAT) begin
        check("vec_rd_value",  64'(bus.wb_rd_value),      64'(vec[c-LAT].exp_val));
        check("vec_rob_id",    64'(bus.wb_rob_id),        64'(c - LAT));
        check("vec_rd_phy",    64'(bus.wb_rd_phy),        64'(vec[c-LAT].rd_phy));
        check("vec_has_exc",   64'(bus.wb_has_exception), 64'(vec[c-LAT].has_exc));
        check("vec_exc_id",    64'(bus.wb_exception_id),  64'(vec[c-LAT].exc_id));
        check("vec_exc_value", 64'(bus.wb_exception_value), 64'(vec[c-LAT].src1 ^ vec[c-LAT].src2));
        check("vec_fb_enable", 64'(bus.fb_enable),        64'(vec[c-LAT].exp_fb));
        if (vec[c-LAT].exp_fb) begin
          check("vec_fb_phy_id", 64'(bus.fb_phy_id), 64'(vec[c-LAT].rd_phy));
          check("vec_fb_value",  64'(bus.fb_value),  64'(vec[c-LAT].exp_val));
        end
      end
    end

    // Back-pressure: wb_full for 2 cycles when the first of 4 ops reaches the output
    bp_exp[0] = 32'd6; bp_exp[1] = 32'd20; bp_exp[2] = 32'd42; bp_exp[3] = 32'd72;
    got.delete();
    begin
      int idx = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (idx < 4) drive(mk(2'd0, 32'(2*idx + 2), 32'(2*idx + 3), 32'd0), 1'b1, 7'(idx));
        else drive(idle, 1'b0, 7'd0);
        bus.wb_full = (c == 3 || c == 4);
        #1;
        if (bus.wb_full) begin
          check("bp_stall_wb_we",    64'(bus.wb_we),    64'd0);
          check("bp_stall_fifo_pop", 64'(bus.fifo_pop), 64'd0);
        end
        if (bus.fifo_pop) idx++;
        if (bus.wb_we) got.push_back(bus.wb_rd_value);
      end
      bus.wb_full = 1'b0;
      check("bp_count", 64'(got.size()), 64'd4);
      for (int k = 0; k < 4; k++)
        check("bp_order", (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'(bp_exp[k]));
    end

    // Flush with op A at the output (and wb_full up), op B behind it; op D follows
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.commit_flush = (c == 3);
      bus.wb_full      = (c == 3);
      if (c == 0)      drive(mk(2'd0, 32'd100, 32'd3, 32'd0), 1'b1, 7'd40);
      else if (c == 1) drive(mk(2'd0, 32'd200, 32'd3, 32'd0), 1'b1, 7'd41);
      else if (c == 3 || c == 4) drive(mk(2'd0, 32'd9, 32'd9, 32'd0), 1'b1, 7'd42);
      else drive(idle, 1'b0, 7'd0);
      #1;
      if (c == 3) begin
        check("fl_wb_flush",  64'(bus.wb_flush),  64'd1);
        check("fl_wb_we",     64'(bus.wb_we),     64'd0);
        check("fl_fb_enable", 64'(bus.fb_enable), 64'd0);
        check("fl_fifo_pop",  64'(bus.fifo_pop),  64'd0);
      end else if (c == 4) begin
        check("fl_new_pop", 64'(bus.fifo_pop), 64'd1);
        check("fl_wb_we",   64'(bus.wb_we),    64'd0);
      end else if (c == 7) begin
        check("fl_new_wb_we",    64'(bus.wb_we),       64'd1);
        check("fl_new_value",    64'(bus.wb_rd_value), 64'd81);
        check("fl_new_rob_id",   64'(bus.wb_rob_id),   64'd42);
        check("fl_new_wb_flush", 64'(bus.wb_flush),    64'd0);
      end else if (c >= 2) begin
        check("fl_no_wb", 64'(bus.wb_we), 64'd0);
      end
    end

    // Async reset between edges with three ops in flight
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c < 3) drive(mk(2'd0, 32'(c + 1), 32'd10, 32'd0), 1'b1, 7'(50 + c));
      else drive(idle, 1'b0, 7'd0);
      #1;
    end
    check("ar_before_wb_we", 64'(bus.wb_we), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_wb_we",     64'(bus.wb_we),     64'd0);
    check("ar_fb_enable", 64'(bus.fb_enable), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check("ar_empty_wb_we", 64'(bus.wb_we), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
